// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : switch_allocator
// Brief    : Per-output round-robin switch allocator with credit gating; drives
//            the 5x5 crossbar's registered grant vector. Optional stall
//            counter enabled by defining ALLOC_STATS_EN.
// Revision : 1.0
// ============================================================================
module switch_allocator #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [2:0] targ1,
    input  logic [2:0] targ2,
    input  logic [2:0] targ3,
    input  logic [2:0] targ4,
    input  logic [2:0] targ5,
    input  logic [4:0] credit_ret,
    output logic [4:0] cb_ctrl,
    output logic [4:0] credit_avail,
    output logic       err
`ifdef ALLOC_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int            c_NPORT   = 5;
    localparam logic [CW-1:0] c_CREDITS = CW'(CREDITS);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    logic [4:0]    r_cb_ctrl;
    logic [4:0]    r_credit_avail;
    logic          r_err;
    logic [CW-1:0] r_credit [c_NPORT];
    logic [2:0]    r_rr_ptr [c_NPORT];

    logic [2:0]    w_targ [c_NPORT];
    logic [4:0]    w_live;
    logic [4:0]    w_cand [c_NPORT];
    logic [4:0]    w_grant_out;
    logic [2:0]    w_win [c_NPORT];
    logic [4:0]    w_grant_in;
    logic          w_req_err;
    logic          w_ovf;
    logic [CW-1:0] w_credit_nxt [c_NPORT];

    assign w_targ[0] = targ1;
    assign w_targ[1] = targ2;
    assign w_targ[2] = targ3;
    assign w_targ[3] = targ4;
    assign w_targ[4] = targ5;

    // Candidate matrix and per-output rotating-priority scan.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_live      = '0;
        w_req_err   = 1'b0;
        w_grant_out = '0;
        w_grant_in  = '0;
        for (int i = 0; i < c_NPORT; i++) begin
            // A flit granted last cycle is still visible on req; mask it.
            w_live[i] = req[i] && (w_targ[i] >= 3'd1) && (w_targ[i] <= 3'd5) && !r_cb_ctrl[i];
            if (req[i] && ((w_targ[i] == 3'd0) || (w_targ[i] > 3'd5)))
                w_req_err = 1'b1;
        end
        for (int j = 0; j < c_NPORT; j++) begin
            w_cand[j] = '0;
            w_win[j]  = '0;
            for (int i = 0; i < c_NPORT; i++)
                w_cand[j][i] = w_live[i] && (w_targ[i] == 3'(j + 1)) && (r_credit[j] != '0);
            for (int off = 0; off < c_NPORT; off++) begin
                v_idx = int'(r_rr_ptr[j]) + off;
                if (v_idx >= c_NPORT)
                    v_idx = v_idx - c_NPORT;
                if (!w_grant_out[j] && w_cand[j][v_idx]) begin
                    w_grant_out[j] = 1'b1;
                    w_win[j]       = 3'(v_idx);
                end
            end
            for (int i = 0; i < c_NPORT; i++)
                if (w_grant_out[j] && (w_win[j] == 3'(i)))
                    w_grant_in[i] = 1'b1;
        end
    end

    always_comb begin
        w_ovf = 1'b0;
        for (int j = 0; j < c_NPORT; j++) begin
            w_credit_nxt[j] = r_credit[j];
            if (w_grant_out[j] && !credit_ret[j])
                w_credit_nxt[j] = r_credit[j] - c_ONE;
            else if (!w_grant_out[j] && credit_ret[j]) begin
                if (r_credit[j] == c_CREDITS)
                    w_ovf = 1'b1;
                else
                    w_credit_nxt[j] = r_credit[j] + c_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cb_ctrl      <= '0;
            r_credit_avail <= '1;
            r_err          <= 1'b0;
            for (int j = 0; j < c_NPORT; j++) begin
                r_credit[j] <= c_CREDITS;
                r_rr_ptr[j] <= '0;
            end
        end else begin
            r_cb_ctrl <= w_grant_in;
            r_err     <= r_err | w_req_err | w_ovf;
            for (int j = 0; j < c_NPORT; j++) begin
                r_credit[j]       <= w_credit_nxt[j];
                r_credit_avail[j] <= (w_credit_nxt[j] != '0);
                if (w_grant_out[j])
                    r_rr_ptr[j] <= (w_win[j] == 3'd4) ? 3'd0 : w_win[j] + 3'd1;
            end
        end
    end

    assign cb_ctrl      = r_cb_ctrl;
    assign credit_avail = r_credit_avail;
    assign err          = r_err;

`ifdef ALLOC_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    // Stall = any live request left ungranted, whether by contention or credit.
    assign w_stall = |(w_live & ~w_grant_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// Self-checking bench for switch_allocator: directed scenarios plus randomized
// traffic checked against a distance-based round-robin reference model.
module tb_switch_allocator;

    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [2:0]  targ [5];
    logic [4:0]  credit_ret;
    logic [4:0]  cb_ctrl;
    logic [4:0]  credit_avail;
    logic        err;
`ifdef ALLOC_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state (registered view) and its next values.
    bit [4:0] m_cb;
    int       m_cred [5];
    int       m_ptr [5];
    bit       m_err;
    int       m_stall;
    bit [4:0] n_cb;
    int       n_cred [5];
    int       n_ptr [5];
    bit       n_err;
    int       n_stall;
    bit [4:0] popped;

    switch_allocator #(.CREDITS(CREDITS), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .targ1        (targ[0]),
        .targ2        (targ[1]),
        .targ3        (targ[2]),
        .targ4        (targ[3]),
        .targ5        (targ[4]),
        .credit_ret   (credit_ret),
        .cb_ctrl      (cb_ctrl),
        .credit_avail (credit_avail),
        .err          (err)
`ifdef ALLOC_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [4:0] model_avail();
        bit [4:0] a;
        for (int j = 0; j < 5; j++) a[j] = (m_cred[j] > 0);
        return a;
    endfunction

    task automatic model_reset();
        m_cb = '0; m_err = 0; m_stall = 0; popped = '0;
        for (int j = 0; j < 5; j++) begin m_cred[j] = CREDITS; m_ptr[j] = 0; end
    endtask

    // Winner per output = candidate with the smallest forward distance from the pointer.
    task automatic model_eval();
        bit any_stall;
        n_cb = '0; n_err = m_err; any_stall = 0;
        for (int j = 0; j < 5; j++) begin
            int best, bestd;
            bit inc, dec;
            best = -1; bestd = 99;
            for (int i = 0; i < 5; i++) begin
                if (req[i] && int'(targ[i]) == j + 1 && !m_cb[i] && m_cred[j] > 0) begin
                    int d;
                    d = (i - m_ptr[j] + 5) % 5;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            n_ptr[j] = m_ptr[j];
            if (best >= 0) begin n_cb[best] = 1; n_ptr[j] = (best + 1) % 5; end
            dec = (best >= 0); inc = credit_ret[j];
            n_cred[j] = m_cred[j];
            if (dec && !inc) n_cred[j] = m_cred[j] - 1;
            else if (inc && !dec) begin
                if (m_cred[j] == CREDITS) n_err = 1;
                else n_cred[j] = m_cred[j] + 1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (req[i] && (targ[i] < 1 || targ[i] > 5)) n_err = 1;
            if (req[i] && targ[i] >= 1 && targ[i] <= 5 && !m_cb[i] && !n_cb[i]) any_stall = 1;
        end
        n_stall = (any_stall && m_stall < 65535) ? m_stall + 1 : m_stall;
    endtask

    task automatic model_commit();
        popped = m_cb;
        m_cb = n_cb; m_err = n_err; m_stall = n_stall;
        for (int j = 0; j < 5; j++) begin m_cred[j] = n_cred[j]; m_ptr[j] = n_ptr[j]; end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        model_commit();
        check_eq("cb_ctrl", cb_ctrl, m_cb);
        check_eq("credit_avail", credit_avail, model_avail());
        check_eq("err", err, m_err);
`ifdef ALLOC_STATS_EN
        check_eq("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic clear_inputs();
        req = '0; credit_ret = '0;
        for (int i = 0; i < 5; i++) targ[i] = 3'd0;
    endtask

    // Asserted away from the clock edge; outputs must clear without an edge.
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        #1;
        check_eq("rst_cb", cb_ctrl, 5'b00000);
        check_eq("rst_avail", credit_avail, 5'b11111);
        check_eq("rst_err", err, 1'b0);
`ifdef ALLOC_STATS_EN
        check_eq("rst_stall", stall_cnt, 16'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rand_inputs(input int p_req, input int p_bad, input int p_ret);
        for (int i = 0; i < 5; i++) begin
            if (popped[i] || !req[i] || targ[i] < 1 || targ[i] > 5) begin
                req[i] = ($urandom % 100) < p_req;
                if (($urandom % 100) < p_bad) begin
                    int v;
                    v = $urandom % 3;
                    targ[i] = (v == 0) ? 3'd0 : ((v == 1) ? 3'd6 : 3'd7);
                end else
                    targ[i] = 3'($urandom_range(1, 5));
            end
        end
        for (int j = 0; j < 5; j++)
            credit_ret[j] = (m_cred[j] < CREDITS) && (($urandom % 100) < p_ret);
    endtask

    initial begin
        int cnt, order;
        rst = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // Idle
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("idle_cb", cb_ctrl, 5'b00000);
        end

        // Single requester on output 3: grants alternate, credits run out after 4
        req = 5'b00001; targ[0] = 3'd3;
        cnt = 0;
        cycle(); check_eq("single_n1", cb_ctrl, 5'b00001); cnt += int'(cb_ctrl[0]);
        cycle(); check_eq("single_n2", cb_ctrl, 5'b00000); cnt += int'(cb_ctrl[0]);
        for (int k = 0; k < 8; k++) begin cycle(); cnt += int'(cb_ctrl[0]); end
        check_eq("single_grants", 32'(cnt), 32'd4);
        check_eq("single_avail", credit_avail, 5'b11011);
        credit_ret = 5'b00100;
        cycle();
        credit_ret = 5'b00000;
        check_eq("ret_nogrant", cb_ctrl, 5'b00000);
        cycle();
        check_eq("ret_regrant", cb_ctrl, 5'b00001);
        do_reset();

        // Contention on output 2: inputs 1,2,5; each drops req once granted
        req = 5'b10011; targ[0] = 3'd2; targ[1] = 3'd2; targ[4] = 3'd2;
        order = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            credit_ret = 5'b00000;
            for (int i = 0; i < 5; i++)
                if (cb_ctrl[i]) begin order = order * 8 + i + 1; req[i] = 1'b0; credit_ret = 5'b00010; end
        end
        check_eq("rr_order", 32'(order), 32'd85);
        req = 5'b10001;
        order = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            credit_ret = 5'b00000;
            for (int i = 0; i < 5; i++)
                if (cb_ctrl[i]) begin order = order * 8 + i + 1; req[i] = 1'b0; credit_ret = 5'b00010; end
        end
        check_eq("rr_wrap", 32'(order), 32'd13);
        do_reset();

        // Parallel grants to distinct outputs
        req = 5'b11111;
        targ[0] = 3'd2; targ[1] = 3'd3; targ[2] = 3'd4; targ[3] = 3'd5; targ[4] = 3'd1;
        cycle(); check_eq("par_1", cb_ctrl, 5'b11111);
        cycle(); check_eq("par_2", cb_ctrl, 5'b00000);
        cycle(); check_eq("par_3", cb_ctrl, 5'b11111);
        do_reset();

        // Invalid target, then credit overflow
        req = 5'b01000; targ[3] = 3'd7;
        for (int k = 0; k < 4; k++) begin cycle(); check_eq("bad_targ_cb", cb_ctrl, 5'b00000); end
        check_eq("bad_targ_err", err, 1'b1);
        do_reset();
        credit_ret = 5'b00001;
        cycle();
        credit_ret = 5'b00000;
        check_eq("ovf_err", err, 1'b1);
        check_eq("ovf_avail", credit_avail, 5'b11111);
        do_reset();

        // Grant and credit return on the same edge with counter at 1
        req = 5'b00001; targ[0] = 3'd1;
        for (int k = 0; k < 6; k++) cycle();
        credit_ret = 5'b00001;
        cycle();
        credit_ret = 5'b00000;
        check_eq("sim_cb", cb_ctrl, 5'b00001);
        check_eq("sim_avail0", credit_avail[0], 1'b1);
        cycle();
        check_eq("sim_avail0_hold", credit_avail[0], 1'b1);
        do_reset();

`ifdef ALLOC_STATS_EN
        // Three inputs on output 1: a live request is left waiting every cycle
        req = 5'b00111; targ[0] = 3'd1; targ[1] = 3'd1; targ[2] = 3'd1;
        for (int k = 0; k < 3; k++) cycle();
        check_eq("stall_3", stall_cnt, 16'd3);
        do_reset();
`endif

        // Randomized traffic with a mid-run asynchronous reset
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            if (k < 2500) rand_inputs(70, 0, 40);
            else rand_inputs(60, 3, 30);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
